// File: rtl/alu_md_unit.sv
// rtl/alu_md_unit.sv - execute unit: single-cycle base integer ops plus iterative M-extension mul/div
module alu_md_unit #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [3:0]      alu_instr,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [SHW:0]    CNT_ONE  = {{SHW{1'b0}}, 1'b1};
    localparam logic [SHW:0]    CNT_INIT = (SHW+1)'(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state, state_next;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     operand;
    logic [SHW:0]        count;
    logic [2:0]          op_q;
    logic                neg_p;
    logic                neg_r;

    // Accept-cycle decode
    logic                a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf, quick;
    logic [XLEN-1:0]     alu_res, quick_res;
    logic [SHW-1:0]      shamt;

    // Iteration datapath
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       r_shift, diff;
    logic [2*XLEN-1:0]   step_mul, step_div, step;
    logic [2*XLEN-1:0]   prod_f;
    logic [XLEN-1:0]     quot_f, rem_f, final_res;
    logic                last;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == CALC);

    always_comb begin
        shamt   = op_b[SHW-1:0];
        alu_res = '0;
        case (alu_instr)
            4'b0010: alu_res = op_a + op_b;
            4'b0110: alu_res = op_a - op_b;
            4'b0100: alu_res = op_a << shamt;
            4'b0101: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'b1001: alu_res = op_a ^ op_b;
            4'b1000: alu_res = op_a >> shamt;
            4'b0011: alu_res = $unsigned($signed(op_a) >>> shamt);
            4'b0001: alu_res = op_a | op_b;
            4'b0000: alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        a_signed  = (md_op == 3'b001) || (md_op == 3'b010) || (md_op == 3'b100) || (md_op == 3'b110);
        b_signed  = (md_op == 3'b001) || (md_op == 3'b100) || (md_op == 3'b110);
        a_neg     = a_signed && op_a[XLEN-1];
        b_neg     = b_signed && op_b[XLEN-1];
        a_mag     = a_neg ? -op_a : op_a;
        b_mag     = b_neg ? -op_b : op_b;
        div_zero  = md_op[2] && (op_b == '0);
        div_ovf   = md_op[2] && !md_op[0] && (op_a == MOST_NEG) && (op_b == '1);
        quick     = !md_en || div_zero || div_ovf;
        quick_res = alu_res;
        if (md_en && div_zero)
            quick_res = md_op[1] ? op_a : '1;
        else if (md_en && div_ovf)
            quick_res = md_op[1] ? '0 : op_a;
    end

    // Multiply shifts the multiplier out of the low half while partial sums enter the top;
    // divide keeps the partial remainder in the high half and the quotient in the low half.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        step_mul = {mul_sum, acc[XLEN-1:1]};
        r_shift  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff     = r_shift - {1'b0, operand};
        if (!diff[XLEN])
            step_div = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            step_div = {r_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        step      = op_q[2] ? step_div : step_mul;
        prod_f    = neg_p ? -step : step;
        quot_f    = neg_p ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem_f     = neg_r ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        if (op_q[2])
            final_res = op_q[1] ? rem_f : quot_f;
        else
            final_res = (op_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
        last = (count == CNT_ONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) state_next = quick ? DONE : CALC;
                CALC: if (last) state_next = DONE;
                DONE: if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result  <= '0;
            acc     <= '0;
            operand <= '0;
            count   <= '0;
            op_q    <= '0;
            neg_p   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (!flush) begin
            if (state == IDLE && in_valid) begin
                if (quick) begin
                    result <= quick_res;
                end else begin
                    op_q  <= md_op;
                    neg_p <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                    count <= CNT_INIT;
                    if (md_op[2]) begin
                        acc     <= {{XLEN{1'b0}}, a_mag};
                        operand <= b_mag;
                    end else begin
                        acc     <= {{XLEN{1'b0}}, b_mag};
                        operand <= a_mag;
                    end
                end
            end else if (state == CALC) begin
                acc   <= step;
                count <= count - CNT_ONE;
                if (last)
                    result <= final_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_md_unit.sv
// tb/tb_alu_md_unit.sv - directed self-checking bench for alu_md_unit (XLEN=32 and XLEN=64)
module tb_alu_md_unit;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, md_en, out_valid, out_ready, busy;
    logic [31:0] op_a, op_b, result;
    logic [3:0]  alu_instr;
    logic [2:0]  md_op;

    logic        in_valid64, in_ready64, md_en64, out_valid64, out_ready64, busy64, flush64;
    logic [63:0] op_a64, op_b64, result64;
    logic [3:0]  alu_instr64;
    logic [2:0]  md_op64;

    int tests  = 0;
    int failed = 0;
    int lat, busy_cnt;
    logic [31:0] held;

    always #5 clk = ~clk;

    alu_md_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .alu_instr(alu_instr), .md_en(md_en), .md_op(md_op),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    alu_md_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
        .op_a(op_a64), .op_b(op_b64), .alu_instr(alu_instr64), .md_en(md_en64), .md_op(md_op64),
        .out_valid(out_valid64), .out_ready(out_ready64), .result(result64), .busy(busy64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one op, wait for out_valid (bounded), report latency and busy cycles, leave it in DONE.
    task automatic issue(input logic m, input logic [3:0] code, input logic [2:0] mop,
                         input logic [31:0] a, input logic [31:0] b);
        md_en = m; alu_instr = code; md_op = mop; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = 32'h0; op_b = 32'h0; md_op = 3'b000; alu_instr = 4'hF;
        lat = 1; busy_cnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic m, input logic [3:0] code,
                          input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat);
        issue(m, code, mop, a, b);
        check({tag, " result"}, result, exp);
        check({tag, " latency"}, lat, exp_lat);
        if (exp_lat == 33) check({tag, " busy cycles"}, busy_cnt, 32);
        consume();
        check({tag, " out_valid drop"}, out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; md_en = 1'b0;
        md_op = 3'b000; alu_instr = 4'h0; op_a = 32'h0; op_b = 32'h0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; md_en64 = 1'b0; md_op64 = 3'b000; flush64 = 1'b0;
        alu_instr64 = 4'h0; op_a64 = 64'h0; op_b64 = 64'h0;
        in_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("reset out_valid", out_valid, 1'b0);
        check("reset result", result, 32'h0);
        check("reset busy", busy, 1'b0);
        check("reset in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check("in_ready after reset", in_ready, 1'b1);
        @(posedge clk); #1;

        run_op("ADD ovf",   1'b0, 4'b0010, 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
        run_op("SRA",       1'b0, 4'b0011, 3'b000, 32'h80000000, 32'h00000024, 32'hF8000000, 1);
        run_op("SUB wrap",  1'b0, 4'b0110, 3'b000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1);
        run_op("SLT",       1'b0, 4'b0101, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
        run_op("SLTU",      1'b0, 4'b0111, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
        run_op("SRL",       1'b0, 4'b1000, 3'b000, 32'h80000000, 32'h00000024, 32'h08000000, 1);
        run_op("SLL",       1'b0, 4'b0100, 3'b000, 32'h00000003, 32'h0000001F, 32'h80000000, 1);
        run_op("XOR",       1'b0, 4'b1001, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
        run_op("OR",        1'b0, 4'b0001, 3'b000, 32'hF0F0F0F0, 32'h0000FF00, 32'hF0F0FFF0, 1);
        run_op("AND",       1'b0, 4'b0000, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1);
        run_op("bad code",  1'b0, 4'b1111, 3'b000, 32'h12345678, 32'h1, 32'h00000000, 1);

        run_op("MUL",       1'b1, 4'h0, 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
        run_op("MULH",      1'b1, 4'h0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
        run_op("MULHU",     1'b1, 4'h0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("MULHSU",    1'b1, 4'h0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("MUL 3x5",   1'b1, 4'h0, 3'b000, 32'h00000003, 32'h00000005, 32'h0000000F, 33);
        run_op("DIV -7/2",  1'b1, 4'h0, 3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
        run_op("REM -7/2",  1'b1, 4'h0, 3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
        run_op("DIVU 7/2",  1'b1, 4'h0, 3'b101, 32'h00000007, 32'h00000002, 32'h00000003, 33);
        run_op("REMU 7/2",  1'b1, 4'h0, 3'b111, 32'h00000007, 32'h00000002, 32'h00000001, 33);
        run_op("DIV 7/-2",  1'b1, 4'h0, 3'b100, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
        run_op("DIVU /0",   1'b1, 4'h0, 3'b101, 32'd100, 32'h0, 32'hFFFFFFFF, 1);
        run_op("REMU /0",   1'b1, 4'h0, 3'b111, 32'd100, 32'h0, 32'd100, 1);
        run_op("DIV ovf",   1'b1, 4'h0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM ovf",   1'b1, 4'h0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

        // Backpressure: DONE held for 5 cycles while new ops are offered.
        issue(1'b1, 4'h0, 3'b101, 32'd7, 32'd2);
        check("bp first result", result, 32'd3);
        for (int i = 0; i < 5; i++) begin
            md_en = 1'b0; alu_instr = 4'b0010; op_a = 32'd1000 + i; op_b = 32'd1; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp result stable", result, 32'd3);
            check("bp in_ready low", in_ready, 1'b0);
            check("bp out_valid held", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        consume();
        check("bp ignored op result", result, 32'd3);
        check("bp back to idle", in_ready, 1'b1);

        // Flush on cycle 10 of a DIV.
        held = result;
        md_en = 1'b1; md_op = 3'b100; op_a = 32'd100; op_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
        check("flush pre busy", busy, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush idle", in_ready, 1'b1);
        check("flush busy", busy, 1'b0);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) lat++;
            @(posedge clk); #1;
        end
        check("flush out_valid never", lat, 0);
        check("flush result kept", result, held);

        // Asynchronous reset mid-CALC.
        md_en = 1'b1; md_op = 3'b000; op_a = 32'd9; op_b = 32'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        check("pre-reset busy", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", busy, 1'b0);
        check("async rst out_valid", out_valid, 1'b0);
        check("async rst result", result, 32'h0);
        @(posedge clk); #2 rst = 1'b0;
        #1 check("in_ready after async rst", in_ready, 1'b1);
        @(posedge clk); #1;
        run_op("post-rst ADD", 1'b0, 4'b0010, 3'b000, 32'd2, 32'd3, 32'd5, 1);

        // XLEN=64: a 6-bit shift amount.
        md_en64 = 1'b0; alu_instr64 = 4'b0100; op_a64 = 64'h1; op_b64 = 64'd63; in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        check("x64 SLL valid", out_valid64, 1'b1);
        check("x64 SLL 63", result64, 64'h8000000000000000);
        out_ready64 = 1'b1;
        @(posedge clk); #1;
        out_ready64 = 1'b0;
        md_en64 = 1'b1; md_op64 = 3'b011; op_a64 = '1; op_b64 = '1; in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        lat = 1;
        while (!out_valid64 && lat < 200) begin @(posedge clk); #1; lat++; end
        check("x64 MULHU latency", lat, 65);
        check("x64 MULHU", result64, 64'hFFFFFFFFFFFFFFFE);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
Parametrised execute unit that replaces the single-cycle ALU in the next core generation.
- Supports all RV base integer ops at any XLEN.
- Adds RV M-extension multiply/divide/remainder as iterative multi-cycle operations.
- Sits between decode/operand-select and writeback, using a valid/ready handshake on both sides so the pipeline controller can stall on long operations.

Parameters:
XLEN, 32, operand/result width (32 or 64)
SHW, $clog2(XLEN), shift-amount width (derived, not overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort of any in-flight op
in_valid  in  1  operation presented
in_ready  out  1  unit can accept an op
op_a  in  XLEN  operand 1
op_b  in  XLEN  operand 2
alu_instr  in  4  base-op code, used when md_en=0
md_en  in  1  1 = M-extension op
md_op  in  3  M op select (func3 encoding)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  XLEN  registered result
busy  out  1  high in CALC state

Behaviour:
- Reset is asynchronous and active-high on rst, single clock clk. While rst is asserted:
  - state=IDLE, result=0, out_valid=0, busy=0, internal counters/accumulators cleared.
  - in_valid is ignored.
- Base codes (md_en=0):
  - 0010 ADD, 0110 SUB, 0100 SLL, 0101 SLT (signed), 0111 SLTU, 1001 XOR, 1000 SRL, 0011 SRA, 0001 OR, 0000 AND.
  - Any other code gives result 0.
  - Shift amount is op_b[SHW-1:0] for SLL/SRL/SRA.
  - SLT/SLTU return a zero-extended 1 or 0.
  - Add/sub wrap modulo 2^XLEN.
- M codes (md_en=1):
  - 000 MUL (low XLEN bits), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high).
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states IDLE, CALC, DONE:
  - in_ready = (state==IDLE) and not rst. An op is accepted on a clk edge with in_valid && in_ready.
  - IDLE, base op accepted: result computed and registered; go to DONE. out_valid is high 1 cycle after acceptance.
  - IDLE, M op accepted: operands are latched as magnitudes, sign flags recorded, counter = XLEN; go to CALC.
  - IDLE, DIV/DIVU/REM/REMU with op_b==0: go straight to DONE (latency 1).
    - Quotient = all ones.
    - Remainder = op_a.
  - IDLE, DIV/REM with op_a = most-negative and op_b = all-ones (signed overflow): go straight to DONE (latency 1).
    - Quotient = op_a.
    - Remainder = 0.
  - CALC: one bit per cycle.
    - Multiply: shift-add into a 2·XLEN accumulator.
    - Divide: restoring, one quotient bit per cycle.
    - Counter decrements each cycle. When it reaches 0, apply sign correction, register result, go to DONE.
    - Total M-op latency = XLEN+1 cycles from acceptance to out_valid (33 for XLEN=32).
  - Sign rules:
    - Product is negated if operand signs differ (signed operands only).
    - Quotient is negated if signs differ.
    - Remainder takes the dividend's sign.
  - DONE: out_valid=1 and result is held stable. On out_ready=1 go to IDLE and drop out_valid. Back-to-back acceptance happens no earlier than the next cycle.
- busy=1 only in CALC.
- flush=1 at any clk edge:
  - Next state IDLE, out_valid=0.
  - In-flight result discarded; result register keeps its last value.
  - flush has priority over acceptance and completion in the same cycle.
- Async rst mid-CALC clears everything immediately; no partial result appears.
- Operands and op select only need to be valid in the accept cycle. Changes during CALC/DONE have no effect.

Test Plan:
- Reset mid-operation: assert rst during CALC → out_valid/result/busy go to 0 immediately (asynchronously), in_ready=1 after release.
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, out_valid exactly 1 cycle after accept. SRA 0x80000000 by op_b=0x00000024 (shamt 4) → 0xF8000000.
- op_a=op_b=0xFFFFFFFF:
  - MUL → 0x00000001.
  - MULH → 0x00000000.
  - MULHU → 0xFFFFFFFE.
  - MULHSU → 0xFFFFFFFF.
  - Each takes 33 cycles, with busy high for 32 of them.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 7/2 → 3; REMU → 1.
- DIVU 100/0 → 0xFFFFFFFF, REMU → 100; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, REM → 0; all with latency 1.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, new in_valid ignored.
  - flush on cycle 10 of a DIV → IDLE next cycle, out_valid never asserts.
- XLEN=64 instance: SLL 1 by op_b=63 → 0x8000000000000000, confirming a 6-bit shamt.
